// File: rtl/gbar_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : gbar_unit_pkg
// Brief    : Shared types and width helpers for the global-barrier unit and
//            the per-core gbar bus interface.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gbar_unit_pkg;

  // Width of an index that can address n items; never narrower than one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GBAR_NUM_REQS     = 4;
  localparam int GBAR_NUM_BARRIERS = 4;
  localparam int GBAR_NB_WIDTH     = log2up(GBAR_NUM_BARRIERS);
  localparam int GBAR_NC_WIDTH     = log2up(GBAR_NUM_REQS);

  // Barrier arrival request as carried on the bus interface.
  typedef struct packed {
    logic [GBAR_NB_WIDTH-1:0] id;
    logic [GBAR_NC_WIDTH-1:0] size_m1;
    logic [GBAR_NC_WIDTH-1:0] core_id;
  } gbar_req_t;

endpackage

`default_nettype wire

// File: rtl/gbar_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : gbar_rr_arbiter
// Brief    : NUM_REQS-way round-robin arbiter. One-hot grant plus index; the
//            priority pointer moves past the winner and holds on idle cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gbar_rr_arbiter
  import gbar_unit_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = log2up(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] i_valid,
  output logic [NUM_REQS-1:0] o_grant,
  output logic [IDX_W-1:0]    o_index,
  output logic                o_any
);

  logic [IDX_W-1:0] r_ptr;

  // Pick the first valid requester at or after the pointer, wrapping around.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      for (int j = 0; j < NUM_REQS; j++) begin
        if (!o_any && i_valid[j] && (((int'(r_ptr) + k) % NUM_REQS) == j)) begin
          o_any      = 1'b1;
          o_grant[j] = 1'b1;
          o_index    = IDX_W'(j);
        end
      end
    end
  end

  // Highest priority moves to the slot after the winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_index == IDX_W'(NUM_REQS - 1)) ? '0 : o_index + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/gbar_unit.sv
//------------------------------------------------------------------------------
// Module   : gbar_unit
// Brief    : Cluster-level global-barrier responder. Tracks per-barrier arrival
//            masks and broadcasts a one-cycle release when enough cores arrive.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gbar_unit
  import gbar_unit_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NB_WIDTH     = log2up(NUM_BARRIERS),
  parameter int NC_WIDTH     = log2up(NUM_REQS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0][NB_WIDTH-1:0]  req_id,
  input  logic [NUM_REQS-1:0][NC_WIDTH-1:0]  req_size_m1,
  input  logic [NUM_REQS-1:0][NC_WIDTH-1:0]  req_core_id,
  output logic [NUM_REQS-1:0]                req_ready,
  output logic                               rsp_valid,
  output logic [NB_WIDTH-1:0]                rsp_id,
  output logic                               busy,
  output logic                               err_dup,
  output logic                               err_size
);

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } req_sel_t;

  logic [NUM_REQS-1:0] r_mask [NUM_BARRIERS];
  logic [NC_WIDTH-1:0] r_size [NUM_BARRIERS];
  logic                r_rsp_valid;
  logic [NB_WIDTH-1:0] r_rsp_id;
  logic                r_err_dup;
  logic                r_err_size;

  logic [NUM_REQS-1:0] w_grant;
  logic [NC_WIDTH-1:0] w_gidx;
  logic                w_any;
  logic                w_accept;
  req_sel_t            w_sel;
  logic [NUM_REQS-1:0] w_mask_old;
  logic [NUM_REQS-1:0] w_bit;
  logic [NUM_REQS-1:0] w_mask_n;
  logic                w_first;
  logic                w_dup;
  logic [NC_WIDTH-1:0] w_size_eff;
  logic [NC_WIDTH:0]   w_cnt;
  logic                w_release;

  gbar_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .IDX_W    (NC_WIDTH)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_valid (req_valid),
    .o_grant (w_grant),
    .o_index (w_gidx),
    .o_any   (w_any)
  );

  // Grants are withheld while reset is held so nothing is handshaken then.
  assign req_ready = w_grant & {NUM_REQS{reset}};
  assign w_accept  = w_any & reset;

  // Granted request, its barrier's current mask, and the release decision.
  // The popcount and target are one bit wider so size_m1 = NUM_REQS-1 fits.
  always_comb begin
    w_sel.id      = req_id[w_gidx];
    w_sel.size_m1 = req_size_m1[w_gidx];
    w_sel.core_id = req_core_id[w_gidx];
    w_mask_old    = r_mask[w_sel.id];
    w_bit         = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_bit[k] = (w_sel.core_id == NC_WIDTH'(k));
    end
    w_first    = (w_mask_old == '0);
    w_dup      = |(w_mask_old & w_bit);
    w_mask_n   = w_mask_old | w_bit;
    w_size_eff = w_first ? w_sel.size_m1 : r_size[w_sel.id];
    w_cnt      = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_cnt = w_cnt + {{NC_WIDTH{1'b0}}, w_mask_n[k]};
    end
    w_release = w_accept && !w_dup &&
                (w_cnt == ({1'b0, w_size_eff} + (NC_WIDTH+1)'(1)));
  end

  // Arrival masks and latched sizes; a duplicate leaves the barrier untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        r_mask[b] <= '0;
        r_size[b] <= '0;
      end
    end else if (w_accept && !w_dup) begin
      r_mask[w_sel.id] <= w_release ? '0 : w_mask_n;
      if (w_first) begin
        r_size[w_sel.id] <= w_sel.size_m1;
      end
    end
  end

  // Release pulse, released id and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_err_dup   <= 1'b0;
      r_err_size  <= 1'b0;
    end else begin
      r_rsp_valid <= w_release;
      if (w_release) begin
        r_rsp_id <= w_sel.id;
      end
      if (w_accept && w_dup) begin
        r_err_dup <= 1'b1;
      end
      if (w_accept && !w_dup && !w_first && (w_sel.size_m1 != r_size[w_sel.id])) begin
        r_err_size <= 1'b1;
      end
    end
  end

  // Busy whenever any barrier holds at least one arrival.
  always_comb begin
    busy = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      busy = busy | (|r_mask[b]);
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign err_dup   = r_err_dup;
  assign err_size  = r_err_size;

endmodule

`default_nettype wire

// File: tb/tb_gbar_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_gbar_unit
// Brief    : Self-checking bench for gbar_unit with a set-based barrier model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gbar_unit;

  localparam int N   = 4;
  localparam int NB  = 4;
  localparam int NBW = 2;
  localparam int NCW = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [N-1:0]              req_valid;
  logic [N-1:0][NBW-1:0]     req_id;
  logic [N-1:0][NCW-1:0]     req_size_m1;
  logic [N-1:0][NCW-1:0]     req_core_id;
  logic [N-1:0]              req_ready;
  logic                      rsp_valid;
  logic [NBW-1:0]            rsp_id;
  logic                      busy;
  logic                      err_dup;
  logic                      err_size;

  gbar_unit #(
    .NUM_REQS     (N),
    .NUM_BARRIERS (NB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_size_m1 (req_size_m1),
    .req_core_id (req_core_id),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .busy        (busy),
    .err_dup     (err_dup),
    .err_size    (err_size)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  // Reference model: per-barrier set of arrived cores, latched size,
  // rotating priority and the expected registered outputs.
  bit [N-1:0] m_mask [NB];
  int         m_size [NB];
  int         m_ptr;
  bit         m_dup, m_serr, m_rv;
  int         m_rid;

  // Observation logs used by the directed literal checks.
  int grant_log[$];
  int grant_cyc[$];
  int rsp_log[$];
  int rsp_cyc[$];

  always @(negedge clk) begin : p_compare
    int         g, id, sz, cid, idx;
    bit [N-1:0] eg, nm;
    bit         eb;
    if (!reset) begin
      for (int b = 0; b < NB; b++) begin
        m_mask[b] = '0;
        m_size[b] = 0;
      end
      m_ptr = 0; m_dup = 0; m_serr = 0; m_rv = 0; m_rid = 0;
      chk("req_ready_in_reset", req_ready, 0);
      chk("rsp_valid_in_reset", rsp_valid, 0);
      chk("rsp_id_in_reset",    rsp_id,    0);
      chk("busy_in_reset",      busy,      0);
      chk("err_dup_in_reset",   err_dup,   0);
      chk("err_size_in_reset",  err_size,  0);
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      eb = 1'b0;
      for (int b = 0; b < NB; b++) if (m_mask[b] != 0) eb = 1'b1;
      chk("req_ready", req_ready, eg);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_id",    rsp_id,    m_rid);
      chk("busy",      busy,      eb);
      chk("err_dup",   err_dup,   m_dup);
      chk("err_size",  err_size,  m_serr);
      for (int k = 0; k < N; k++) begin
        if (req_ready[k]) begin
          grant_log.push_back(k);
          grant_cyc.push_back(cyc);
        end
      end
      if (rsp_valid) begin
        rsp_log.push_back(int'(rsp_id));
        rsp_cyc.push_back(cyc);
      end
      m_rv = 1'b0;
      if (g >= 0) begin
        id    = int'(req_id[g]);
        sz    = int'(req_size_m1[g]);
        cid   = int'(req_core_id[g]);
        m_ptr = (g + 1) % N;
        if (m_mask[id][cid]) begin
          m_dup = 1'b1;
        end else begin
          if (m_mask[id] == 0) m_size[id] = sz;
          else if (sz != m_size[id]) m_serr = 1'b1;
          nm = m_mask[id];
          nm[cid] = 1'b1;
          if ($countones(nm) == m_size[id] + 1) begin
            m_mask[id] = '0;
            m_rv       = 1'b1;
            m_rid      = id;
          end else begin
            m_mask[id] = nm;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete();
    rsp_log.delete();   rsp_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    clear_logs();
  endtask

  // Present one request on core c and hold it until granted.
  task automatic send(input int c, input int id, input int sz, input int cid);
    int waited;
    bit got;
    waited = 0;
    got    = 1'b0;
    req_id[c]      = NBW'(id);
    req_size_m1[c] = NCW'(sz);
    req_core_id[c] = NCW'(cid);
    req_valid[c]   = 1'b1;
    while (!got && waited < 64) begin
      @(negedge clk);
      if (req_ready[c]) got = 1'b1;
      waited++;
    end
    if (!got) begin
      vectors++;
      fails++;
      $display("FAIL send_timeout core %0d: granted=0, expected grant within 64 cycles", c);
    end
    @(posedge clk);
    #1;
    req_valid[c] = 1'b0;
  endtask

  int size_tab[NB] = '{3, 1, 2, 0};

  task automatic rand_core(input int c, input int n);
    int id, sz, cid;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      id  = int'($urandom_range(0, NB - 1));
      sz  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : size_tab[id];
      cid = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : c;
      send(c, id, sz, cid);
    end
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = '0;
    req_id      = '0;
    req_size_m1 = '0;
    req_core_id = '0;
    idle(2);
    reset = 1'b1;
    idle(1);
    clear_logs();

    // Contention: all cores together -> grants 0,1,2,3, release one cycle later.
    fork
      send(0, 0, 3, 0);
      send(1, 0, 3, 1);
      send(2, 0, 3, 2);
      send(3, 0, 3, 3);
    join
    idle(3);
    chk("contention_grants", grant_log.size(), 4);
    for (int k = 0; k < 4; k++) chk("contention_order", qget(grant_log, k), k);
    chk("contention_rsp_count", rsp_log.size(), 1);
    chk("contention_rsp_id", qget(rsp_log, 0), 0);
    chk("contention_rsp_latency", qget(rsp_cyc, 0), qget(grant_cyc, 3) + 1);

    // Basic sequential release on id 2.
    clear_logs();
    send(0, 2, 3, 0);
    send(1, 2, 3, 1);
    send(2, 2, 3, 2);
    send(3, 2, 3, 3);
    chk("basic_rsp_valid", rsp_valid, 1);
    chk("basic_rsp_id", rsp_id, 2);
    chk("basic_busy", busy, 0);
    idle(2);
    chk("basic_rsp_count", rsp_log.size(), 1);

    // Interleaved barriers 1 and 3 -> back-to-back releases.
    clear_logs();
    fork
      send(0, 1, 1, 0);
      send(1, 3, 1, 1);
      send(2, 1, 1, 2);
      send(3, 3, 1, 3);
    join
    idle(3);
    chk("interleave_rsp_count", rsp_log.size(), 2);
    chk("interleave_first_id", qget(rsp_log, 0), 1);
    chk("interleave_second_id", qget(rsp_log, 1), 3);
    chk("interleave_back_to_back", qget(rsp_cyc, 1), qget(rsp_cyc, 0) + 1);

    // Duplicate arrival.
    do_reset();
    send(2, 0, 2, 2);
    send(2, 0, 2, 2);
    idle(3);
    chk("dup_err_dup", err_dup, 1);
    chk("dup_err_size", err_size, 0);
    chk("dup_busy", busy, 1);
    chk("dup_no_rsp", rsp_log.size(), 0);
    send(0, 0, 2, 0);
    send(1, 0, 2, 1);
    idle(2);
    chk("dup_release_count", rsp_log.size(), 1);
    chk("dup_release_id", qget(rsp_log, 0), 0);
    chk("dup_busy_after", busy, 0);

    // Size mismatch resolved with latched size, then a trivial barrier.
    do_reset();
    send(0, 0, 1, 0);
    send(1, 0, 2, 1);
    idle(2);
    chk("size_err_size", err_size, 1);
    chk("size_err_dup", err_dup, 0);
    chk("size_release_count", rsp_log.size(), 1);
    chk("size_release_id", qget(rsp_log, 0), 0);
    send(3, 1, 0, 3);
    chk("trivial_rsp_valid", rsp_valid, 1);
    chk("trivial_rsp_id", rsp_id, 1);
    idle(2);
    chk("trivial_rsp_count", rsp_log.size(), 2);

    // Reset in the middle of an episode.
    do_reset();
    send(0, 2, 3, 0);
    send(1, 2, 3, 1);
    chk("midreset_busy_before", busy, 1);
    req_id[2] = 2'd2; req_size_m1[2] = 2'd3; req_core_id[2] = 2'd2;
    req_valid[2] = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_req_ready", req_ready, 0);
    req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    idle(1);
    clear_logs();
    fork
      send(0, 2, 3, 0);
      send(1, 2, 3, 1);
      send(2, 2, 3, 2);
      send(3, 2, 3, 3);
    join
    idle(3);
    chk("midreset_fresh_count", rsp_log.size(), 1);
    chk("midreset_fresh_id", qget(rsp_log, 0), 2);
    chk("midreset_fresh_busy", busy, 0);

    // Randomized traffic against the model.
    do_reset();
    fork
      rand_core(0, 40);
      rand_core(1, 40);
      rand_core(2, 40);
      rand_core(3, 40);
    join
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
